uart_stream_adapter: RTL and testbench
======================================

UART_STREAM_ADAPTER -- requirements
Module: uart_stream_adapter

Interface
REQ-001 Parameter RX_DEPTH, default 4, meaning RX buffer entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter GUARD_CYCLES, default 2, meaning idle cycles after each UART access before TXRDY/RXRDY are trusted again.
REQ-003 CLK  in  1  system clock; the same clock as the UART core.
REQ-004 RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 TX_DATA  in  8  byte to transmit; TX_VALID  in  1  byte offered; TX_READY  out  1  byte accepted this cycle.
REQ-006 RX_DATA  out  8  received byte; RX_PERR  out  1  parity error for that byte; RX_FERR  out  1  framing error for that byte.
REQ-007 RX_VALID  out  1  RX entry presented; RX_READY  in  1  consumer takes the entry.
REQ-008 UART_CSN, UART_WEN, UART_OEN  out  1 each  active-low UART strobes; UART_DATA_IN  out  8  write data.
REQ-009 UART_DATA_OUT  in  8; UART_TXRDY, UART_RXRDY, UART_PARITY_ERR, UART_FRAMING_ERR, UART_OVERFLOW  in  1 each  UART status.
REQ-010 OVERFLOW_STICKY  out  1  latched UART_OVERFLOW or RX buffer loss; OVF_CLR  in  1  clears the sticky flag.

Function
REQ-011 The FSM SHALL have the states IDLE, WR, RD and GUARD, and the state register SHALL be the only driver of the UART strobes.
REQ-012 In IDLE, an RX access SHALL be eligible when UART_RXRDY=1 and the RX buffer is not full.
REQ-013 In IDLE, a TX access SHALL be eligible when TX_VALID=1 and UART_TXRDY=1.
REQ-014 When both accesses are eligible, the last_was_rd flag SHALL select the access: TX if last_was_rd=1, otherwise RX.
REQ-015 IDLE->WR SHALL assert TX_READY combinationally in the decision cycle and register TX_DATA into UART_DATA_IN.
REQ-016 WR SHALL last exactly 1 cycle, with CSN=0, WEN=0, OEN=1, and SHALL then go to GUARD with last_was_rd=0.
REQ-017 RD SHALL last exactly 1 cycle, with CSN=0, OEN=0, WEN=1.
REQ-018 At the RD cycle edge, {UART_FRAMING_ERR, UART_PARITY_ERR, UART_DATA_OUT} SHALL be pushed into the RX buffer, and the FSM SHALL go to GUARD with last_was_rd=1.
REQ-019 GUARD SHALL count GUARD_CYCLES cycles with all strobes high and then return to IDLE.
REQ-020 UART_TXRDY and UART_RXRDY SHALL be ignored during GUARD.
REQ-021 Strobes SHALL never be low in two consecutive cycles, and WEN and OEN SHALL never be low together.
REQ-022 Access rate: 1 UART access per (2+GUARD_CYCLES) cycles maximum, i.e. 4 cycles at the default.
REQ-023 The RX buffer SHALL be a synchronous FIFO of RX_DEPTH x 10 bits, using log2(RX_DEPTH)-bit pointers with wrap-around and a (log2(RX_DEPTH)+1)-bit count.
REQ-024 RX_VALID SHALL equal (count != 0), and the RX_DATA/RX_PERR/RX_FERR outputs SHALL be driven from the head entry (first-word fall-through).
REQ-025 A pop SHALL occur on RX_VALID & RX_READY.
REQ-026 A simultaneous push and pop SHALL leave the count unchanged, including when the buffer is full.
REQ-027 A push when count = RX_DEPTH SHALL be unreachable by REQ-012, and this SHALL be checked by assertion.
REQ-028 OVERFLOW_STICKY SHALL set on any cycle with UART_OVERFLOW=1.
REQ-029 OVERFLOW_STICKY SHALL clear on OVF_CLR=1 when no set condition is present in the same cycle; a simultaneous set SHALL win.
REQ-030 TX_READY SHALL be 0 in every cycle outside the IDLE->WR decision cycle.
REQ-031 TX_DATA SHALL be held by the source until TX_READY is asserted.

Reset
REQ-032 On RESET_N=0, the following SHALL apply asynchronously: state=IDLE, CSN/WEN/OEN=1, UART_DATA_IN=0x00, guard count=0, last_was_rd=0.
REQ-033 On RESET_N=0, FIFO pointers and count SHALL be 0, RX_VALID=0, RX_DATA=0x00, RX_PERR/RX_FERR=0, TX_READY=0 and OVERFLOW_STICKY=0.
REQ-034 Reset asserted mid-access SHALL release the strobes immediately.
REQ-035 A byte whose RD strobe was cut by reset SHALL be discarded.

Structure
REQ-036 The FSM state encoding and the RX entry width constant (10) SHALL live in the shared uart_pkg package.
REQ-037 The RX buffer SHALL be the single sub-module uart_stream_rxbuf, parameterised by depth and width; the FSM, arbitration and sticky flag SHALL stay in the top.

Verification
REQ-038 Single TX: with TXRDY=1 and TX_VALID with 0xA5 -> TX_READY for 1 cycle, then one cycle later WEN=CSN=0 for 1 cycle with UART_DATA_IN=0xA5, then 2 guard cycles.
REQ-039 Single RX: RXRDY=1 with DATA_OUT=0x3C and PARITY_ERR=1 -> OEN=CSN=0 for 1 cycle, then RX_VALID with RX_DATA=0x3C and RX_PERR=1.
REQ-040 Contention: RXRDY=1 and TX_VALID/TXRDY=1 held continuously -> accesses alternate RD, WR, RD, WR, every 4 cycles.
REQ-041 Backpressure: RX_READY=0 with 5 bytes arriving -> 4 buffered, no 5th OEN strobe until one pop, and FIFO order preserved across pointer wrap.
REQ-042 Overflow: UART_OVERFLOW pulsed for 1 cycle together with OVF_CLR=1 -> sticky=1; OVF_CLR alone next cycle -> sticky=0.
REQ-043 Reset during the WR cycle -> strobes high in the same cycle, state IDLE, RX_VALID=0, and no spurious strobes after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART stream adapter: FSM state encoding and RX entry width.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WR    = 2'd1,
      ST_RD    = 2'd2,
      ST_GUARD = 2'd3
   } state_e;

   // One RX entry is {framing error, parity error, data byte}.
   localparam int RX_ENTRY_W = 10;

endpackage

// File: rtl/uart_stream_rxbuf.sv
// First-word fall-through synchronous FIFO used to buffer received UART bytes.
module uart_stream_rxbuf #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] headData_o,
   output logic             valid_o,
   output logic             full_o,
   output logic             lost_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic             doPush;
   logic             doPop;

   assign valid_o    = (count_q != '0);
   assign full_o     = (count_q == FULL_CNT);
   assign doPop      = pop_i && valid_o;
   // A push into a full buffer is only accepted when the head leaves in the same cycle.
   assign doPush     = push_i && (!full_o || doPop);
   assign lost_o     = push_i && full_o && !doPop;
   assign headData_o = valid_o ? mem_q[rdPtr_q] : '0;

   always_ff @(posedge CLK) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   noPushWhenFull: assert property (@(posedge CLK) disable iff (!RESET_N) !lost_o);

endmodule

// File: rtl/uart_stream_adapter.sv
// Bridges a valid/ready byte stream pair onto a strobe-based UART core, with
// TX/RX arbitration, post-access guard time, an RX buffer and a sticky overflow flag.
module uart_stream_adapter
   import uart_pkg::*;
#(
   parameter int RX_DEPTH     = 4,
   parameter int GUARD_CYCLES = 2
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [7:0] TX_DATA,
   input  logic       TX_VALID,
   output logic       TX_READY,
   output logic [7:0] RX_DATA,
   output logic       RX_PERR,
   output logic       RX_FERR,
   output logic       RX_VALID,
   input  logic       RX_READY,
   output logic       UART_CSN,
   output logic       UART_WEN,
   output logic       UART_OEN,
   output logic [7:0] UART_DATA_IN,
   input  logic [7:0] UART_DATA_OUT,
   input  logic       UART_TXRDY,
   input  logic       UART_RXRDY,
   input  logic       UART_PARITY_ERR,
   input  logic       UART_FRAMING_ERR,
   input  logic       UART_OVERFLOW,
   output logic       OVERFLOW_STICKY,
   input  logic       OVF_CLR
);

   localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
   localparam state_e AFTER_ACCESS = (GUARD_CYCLES > 0) ? ST_GUARD : ST_IDLE;

   state_e                state_q, state_d;
   logic [GW-1:0]         guardCnt_q, guardCnt_d;
   logic                  lastWasRd_q, lastWasRd_d;
   logic [7:0]            dataIn_q, dataIn_d;
   logic                  sticky_q, sticky_d;
   logic                  txReady;
   logic                  rxPush;
   logic                  rxPop;
   logic                  rxFull;
   logic                  rxLost;
   logic                  rxElig;
   logic                  txElig;
   logic [RX_ENTRY_W-1:0] rxHead;

   assign rxElig = UART_RXRDY && !rxFull;
   assign txElig = TX_VALID && UART_TXRDY;
   assign rxPop  = RX_VALID && RX_READY;

   // Strobes decode straight from the state register, so reset releases them at once.
   assign UART_CSN     = !((state_q == ST_WR) || (state_q == ST_RD));
   assign UART_WEN     = (state_q != ST_WR);
   assign UART_OEN     = (state_q != ST_RD);
   assign UART_DATA_IN = dataIn_q;
   assign TX_READY     = txReady && RESET_N;

   assign OVERFLOW_STICKY = sticky_q;
   assign {RX_FERR, RX_PERR, RX_DATA} = rxHead;

   always_comb begin
      state_d     = state_q;
      guardCnt_d  = guardCnt_q;
      lastWasRd_d = lastWasRd_q;
      dataIn_d    = dataIn_q;
      txReady     = 1'b0;
      rxPush      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // On contention the previous access type loses, giving strict alternation.
            if (txElig && (!rxElig || lastWasRd_q)) begin
               state_d  = ST_WR;
               txReady  = 1'b1;
               dataIn_d = TX_DATA;
            end else if (rxElig) begin
               state_d = ST_RD;
            end
         end
         ST_WR: begin
            state_d     = AFTER_ACCESS;
            guardCnt_d  = '0;
            lastWasRd_d = 1'b0;
         end
         ST_RD: begin
            rxPush      = 1'b1;
            state_d     = AFTER_ACCESS;
            guardCnt_d  = '0;
            lastWasRd_d = 1'b1;
         end
         ST_GUARD: begin
            if (guardCnt_q == GUARD_LAST) begin
               state_d = ST_IDLE;
            end else begin
               guardCnt_d = guardCnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A new overflow event in the same cycle as a clear request keeps the flag set.
   always_comb begin
      sticky_d = sticky_q;
      if (UART_OVERFLOW || rxLost) begin
         sticky_d = 1'b1;
      end else if (OVF_CLR) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         guardCnt_q  <= '0;
         lastWasRd_q <= 1'b0;
         dataIn_q    <= '0;
         sticky_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         guardCnt_q  <= guardCnt_d;
         lastWasRd_q <= lastWasRd_d;
         dataIn_q    <= dataIn_d;
         sticky_q    <= sticky_d;
      end
   end

   uart_stream_rxbuf #(
      .DEPTH (RX_DEPTH),
      .WIDTH (RX_ENTRY_W)
   ) rxBuf (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .push_i     (rxPush),
      .pushData_i ({UART_FRAMING_ERR, UART_PARITY_ERR, UART_DATA_OUT}),
      .pop_i      (rxPop),
      .headData_o (rxHead),
      .valid_o    (RX_VALID),
      .full_o     (rxFull),
      .lost_o     (rxLost)
   );

endmodule

// File: tb/tb_uart_stream_adapter.sv
// Directed self-checking bench for uart_stream_adapter at default parameters.
module tb_uart_stream_adapter;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic [7:0] txData = 8'h00;
   logic       txValid = 1'b0;
   logic       txReady;
   logic [7:0] rxData;
   logic       rxPerr;
   logic       rxFerr;
   logic       rxValid;
   logic       rxReady = 1'b0;
   logic       uartCsn;
   logic       uartWen;
   logic       uartOen;
   logic [7:0] uartDataIn;
   logic [7:0] uartDataOut = 8'h00;
   logic       uartTxrdy = 1'b0;
   logic       uartRxrdy = 1'b0;
   logic       uartPerr = 1'b0;
   logic       uartFerr = 1'b0;
   logic       uartOverflow = 1'b0;
   logic       sticky;
   logic       ovfClr = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_stream_adapter dut (
      .CLK              (clk),
      .RESET_N          (resetN),
      .TX_DATA          (txData),
      .TX_VALID         (txValid),
      .TX_READY         (txReady),
      .RX_DATA          (rxData),
      .RX_PERR          (rxPerr),
      .RX_FERR          (rxFerr),
      .RX_VALID         (rxValid),
      .RX_READY         (rxReady),
      .UART_CSN         (uartCsn),
      .UART_WEN         (uartWen),
      .UART_OEN         (uartOen),
      .UART_DATA_IN     (uartDataIn),
      .UART_DATA_OUT    (uartDataOut),
      .UART_TXRDY       (uartTxrdy),
      .UART_RXRDY       (uartRxrdy),
      .UART_PARITY_ERR  (uartPerr),
      .UART_FRAMING_ERR (uartFerr),
      .UART_OVERFLOW    (uartOverflow),
      .OVERFLOW_STICKY  (sticky),
      .OVF_CLR          (ovfClr)
   );

   // Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      tick();
      resetN = 1'b0;
      #2;
      resetN = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      txValid = 1'b1;
      uartTxrdy = 1'b1;
      uartRxrdy = 1'b1;
      uartOverflow = 1'b1;
      #12;
      checks++;
      if ({uartCsn, uartWen, uartOen} !== 3'b111) begin
         failures++;
         $display("[TB] FAIL reset_strobes actual=%b expected=111", {uartCsn, uartWen, uartOen});
      end
      checks++;
      if ({txReady, rxValid, rxPerr, rxFerr, sticky} !== 5'b00000) begin
         failures++;
         $display("[TB] FAIL reset_flags actual=%b expected=00000", {txReady, rxValid, rxPerr, rxFerr, sticky});
      end
      checks++;
      if ({uartDataIn, rxData} !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL reset_data actual=%h expected=0000", {uartDataIn, rxData});
      end
      txValid = 1'b0;
      uartTxrdy = 1'b0;
      uartRxrdy = 1'b0;
      uartOverflow = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
      tick();
      tick();
      checks++;
      if ({uartCsn, uartWen, uartOen, sticky, rxValid} !== 5'b11100) begin
         failures++;
         $display("[TB] FAIL reset_release actual=%b expected=11100", {uartCsn, uartWen, uartOen, sticky, rxValid});
      end
   endtask

   task automatic test_single_tx();
      txData = 8'hA5;
      txValid = 1'b1;
      uartTxrdy = 1'b1;
      #1;
      checks++;
      if (txReady !== 1'b1) begin
         failures++;
         $display("[TB] FAIL tx_ready_decision actual=%b expected=1", txReady);
      end
      tick();
      txData = 8'h5A;
      #1;
      checks++;
      if ({uartCsn, uartWen, uartOen, txReady} !== 4'b0010 || uartDataIn !== 8'hA5) begin
         failures++;
         $display("[TB] FAIL tx_write_cycle actual=%b/%h expected=0010/a5", {uartCsn, uartWen, uartOen, txReady}, uartDataIn);
      end
      for (int g = 0; g < 2; g++) begin
         tick();
         #1;
         checks++;
         if ({uartCsn, uartWen, uartOen, txReady} !== 4'b1110) begin
            failures++;
            $display("[TB] FAIL tx_guard%0d actual=%b expected=1110", g, {uartCsn, uartWen, uartOen, txReady});
         end
      end
      tick();
      #1;
      checks++;
      if (txReady !== 1'b1) begin
         failures++;
         $display("[TB] FAIL tx_ready_after_guard actual=%b expected=1", txReady);
      end
      tick();
      txValid = 1'b0;
      #1;
      checks++;
      if ({uartCsn, uartWen, uartOen} !== 3'b001 || uartDataIn !== 8'h5A) begin
         failures++;
         $display("[TB] FAIL tx_second_write actual=%b/%h expected=001/5a", {uartCsn, uartWen, uartOen}, uartDataIn);
      end
      repeat (3) tick();
   endtask

   task automatic test_single_rx();
      uartRxrdy = 1'b1;
      uartDataOut = 8'h3C;
      uartPerr = 1'b1;
      #1;
      checks++;
      if ({uartCsn, uartWen, uartOen} !== 3'b111) begin
         failures++;
         $display("[TB] FAIL rx_decision_strobes actual=%b expected=111", {uartCsn, uartWen, uartOen});
      end
      tick();
      uartRxrdy = 1'b0;
      #1;
      checks++;
      if ({uartCsn, uartWen, uartOen, rxValid} !== 4'b0100) begin
         failures++;
         $display("[TB] FAIL rx_read_cycle actual=%b expected=0100", {uartCsn, uartWen, uartOen, rxValid});
      end
      tick();
      uartDataOut = 8'h00;
      uartPerr = 1'b0;
      #1;
      checks++;
      if ({rxValid, rxPerr, rxFerr} !== 3'b110 || rxData !== 8'h3C) begin
         failures++;
         $display("[TB] FAIL rx_entry actual=%b/%h expected=110/3c", {rxValid, rxPerr, rxFerr}, rxData);
      end
      rxReady = 1'b1;
      tick();
      rxReady = 1'b0;
      #1;
      checks++;
      if (rxValid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rx_pop actual=%b expected=0", rxValid);
      end
      repeat (2) tick();
   endtask

   task automatic test_contention();
      logic [2:0] expStrobes;
      pulseReset();
      rxReady = 1'b1;
      uartRxrdy = 1'b1;
      uartTxrdy = 1'b1;
      txValid = 1'b1;
      txData = 8'h11;
      uartDataOut = 8'h40;
      for (int c = 0; c < 16; c++) begin
         #1;
         expStrobes = (c % 8 == 1) ? 3'b010 : ((c % 8 == 5) ? 3'b001 : 3'b111);
         checks++;
         if ({uartCsn, uartWen, uartOen} !== expStrobes || txReady !== (c % 8 == 4)) begin
            failures++;
            $display("[TB] FAIL contention_c%0d actual=%b/%b expected=%b/%b", c, {uartCsn, uartWen, uartOen}, txReady, expStrobes, (c % 8 == 4));
         end
         tick();
      end
      uartRxrdy = 1'b0;
      txValid = 1'b0;
      repeat (4) tick();
      rxReady = 1'b0;
   endtask

   task automatic test_back_to_back_backpressure();
      int  oenCount;
      bit  found;
      logic [7:0] expByte;
      pulseReset();
      rxReady = 1'b0;
      uartRxrdy = 1'b1;
      uartDataOut = 8'h80;
      oenCount = 0;
      for (int c = 0; c < 24; c++) begin
         if (c % 4 == 2 && c <= 14) uartDataOut = 8'h80 + 8'(c / 4 + 1);
         #1;
         if (uartOen == 1'b0) oenCount++;
         tick();
      end
      checks++;
      if (oenCount !== 4) begin
         failures++;
         $display("[TB] FAIL bp_read_count actual=%0d expected=4", oenCount);
      end
      rxReady = 1'b1;
      #1;
      checks++;
      if (rxValid !== 1'b1 || rxData !== 8'h80) begin
         failures++;
         $display("[TB] FAIL bp_head actual=%b/%h expected=1/80", rxValid, rxData);
      end
      tick();
      rxReady = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         #1;
         if (uartOen == 1'b0) found = 1'b1;
         else tick();
      end
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL bp_fifth_read actual=none expected=read_within_8");
      end
      tick();
      uartRxrdy = 1'b0;
      rxReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expByte = 8'h81 + 8'(i);
         #1;
         checks++;
         if (rxValid !== 1'b1 || rxData !== expByte) begin
            failures++;
            $display("[TB] FAIL bp_order%0d actual=%b/%h expected=1/%h", i, rxValid, rxData, expByte);
         end
         tick();
      end
      #1;
      checks++;
      if (rxValid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_drained actual=%b expected=0", rxValid);
      end
      rxReady = 1'b0;
   endtask

   task automatic test_overflow();
      tick();
      uartOverflow = 1'b1;
      ovfClr = 1'b1;
      tick();
      uartOverflow = 1'b0;
      #1;
      checks++;
      if (sticky !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ovf_set_wins actual=%b expected=1", sticky);
      end
      tick();
      ovfClr = 1'b0;
      #1;
      checks++;
      if (sticky !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ovf_clear actual=%b expected=0", sticky);
      end
      uartOverflow = 1'b1;
      tick();
      uartOverflow = 1'b0;
      repeat (3) tick();
      checks++;
      if (sticky !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ovf_hold actual=%b expected=1", sticky);
      end
      ovfClr = 1'b1;
      tick();
      ovfClr = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      bit spurious;
      pulseReset();
      uartRxrdy = 1'b1;
      uartDataOut = 8'h77;
      tick();
      uartRxrdy = 1'b0;
      repeat (3) tick();
      checks++;
      if (rxValid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL mid_prefill actual=%b expected=1", rxValid);
      end
      txData = 8'hC3;
      txValid = 1'b1;
      uartTxrdy = 1'b1;
      tick();
      txValid = 1'b0;
      #1;
      checks++;
      if ({uartCsn, uartWen, uartOen} !== 3'b001) begin
         failures++;
         $display("[TB] FAIL mid_wr_entered actual=%b expected=001", {uartCsn, uartWen, uartOen});
      end
      resetN = 1'b0;
      #1;
      checks++;
      if ({uartCsn, uartWen, uartOen, txReady, rxValid} !== 5'b11100 || uartDataIn !== 8'h00) begin
         failures++;
         $display("[TB] FAIL mid_wr_reset actual=%b/%h expected=11100/00", {uartCsn, uartWen, uartOen, txReady, rxValid}, uartDataIn);
      end
      #2;
      resetN = 1'b1;
      spurious = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if ({uartCsn, uartWen, uartOen} !== 3'b111 || rxValid !== 1'b0) spurious = 1'b1;
      end
      checks++;
      if (spurious) begin
         failures++;
         $display("[TB] FAIL mid_wr_after_release actual=activity expected=quiet");
      end
      uartRxrdy = 1'b1;
      uartDataOut = 8'h99;
      tick();
      uartRxrdy = 1'b0;
      resetN = 1'b0;
      #1;
      checks++;
      if ({uartCsn, uartWen, uartOen} !== 3'b111) begin
         failures++;
         $display("[TB] FAIL mid_rd_reset actual=%b expected=111", {uartCsn, uartWen, uartOen});
      end
      #1;
      resetN = 1'b1;
      repeat (6) tick();
      checks++;
      if (rxValid !== 1'b0 || {uartCsn, uartWen, uartOen} !== 3'b111) begin
         failures++;
         $display("[TB] FAIL mid_rd_discard actual=%b/%b expected=0/111", rxValid, {uartCsn, uartWen, uartOen});
      end
   endtask

   initial begin
      test_reset();
      test_single_tx();
      test_single_rx();
      test_contention();
      test_back_to_back_backpressure();
      test_overflow();
      test_reset_mid_access();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
